// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier that borrows the shared ALU for one
// ADD per iteration. Produces the low XLEN bits of op_a*op_b.
module alu_mul_seq #(
  parameter int         XLEN       = 32,
  parameter bit         EARLY_EXIT = 1'b1,
  parameter logic [2:0] ALU_ADD    = 3'b000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_branch,
  input  logic [XLEN-1:0] alu_c
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_iter;

  // Last iteration: counter exhausted, or no multiplier bits left to add.
  assign last_iter = (count_q == CNT_LAST) ||
                     (EARLY_EXIT && ((mplier_q >> 1) == '0));

  // Next-state logic. ALU operands are registered, so they are computed from
  // the next-cycle acc/mcand/mplier to line up with the RUN cycle that uses them.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d    = alu_c;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (last_iter) begin
            result_d = alu_c;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    alu_a_d = (state_d == RUN) ? acc_d : '0;
    alu_b_d = (state_d == RUN && mplier_d[0]) ? mcand_d : '0;
  end

  // FSM and datapath registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign alu_op     = ALU_ADD;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_branch = 1'b0;
endmodule
